// File: rtl/cpm_arb_mi_rr.sv
// rtl/cpm_arb_mi_rr.sv - multi-requester, multi-target round-robin arbiter with burst lock
// Each target runs its own rotating pointer plus an IDLE/LOCKED owner FSM; grants are combinational.
module cpm_arb_mi_rr #(
    parameter int REQ_NUM = 4,
    parameter int TGT_NUM = 4,
    parameter int TGT_AW  = (TGT_NUM > 1) ? $clog2(TGT_NUM) : 1,
    parameter int REQ_AW  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
    parameter bit LOCK_EN = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [REQ_NUM-1:0]          REQ_ARB,
    input  logic [REQ_NUM*TGT_AW-1:0]   REQ_IDX,
    input  logic [REQ_NUM-1:0]          REQ_LAST,
    input  logic [TGT_NUM-1:0]          TGT_RDY,
    output logic [REQ_NUM-1:0]          GNT_ARB,
    output logic [TGT_NUM-1:0]          GNT_VLD,
    output logic [TGT_NUM*REQ_AW-1:0]   GNT_IDX,
    output logic [TGT_NUM-1:0]          LOCK
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t             state_q [TGT_NUM];
    state_t             state_d [TGT_NUM];
    logic [REQ_AW-1:0]  ptr_q   [TGT_NUM];
    logic [REQ_AW-1:0]  ptr_d   [TGT_NUM];
    logic [REQ_AW-1:0]  owner_q [TGT_NUM];
    logic [REQ_AW-1:0]  owner_d [TGT_NUM];
    logic [REQ_AW-1:0]  win     [TGT_NUM];
    logic [TGT_NUM-1:0] win_vld;
    logic [TGT_AW-1:0]  req_tgt [REQ_NUM];

    // Slot k of the rotation starting at base, wrapped explicitly at REQ_NUM.
    function automatic logic [REQ_AW-1:0] rr_slot(input logic [REQ_AW-1:0] base, input int k);
        logic [REQ_AW:0] sum;
        sum = {1'b0, base} + (REQ_AW+1)'(k);
        if (sum >= (REQ_AW+1)'(REQ_NUM)) begin
            sum = sum - (REQ_AW+1)'(REQ_NUM);
        end
        return sum[REQ_AW-1:0];
    endfunction

    function automatic logic [REQ_AW-1:0] next_ptr(input logic [REQ_AW-1:0] r);
        return (r == REQ_AW'(REQ_NUM-1)) ? '0 : r + 1'b1;
    endfunction

    always_comb begin
        for (int r = 0; r < REQ_NUM; r++) begin
            req_tgt[r] = REQ_IDX[r*TGT_AW +: TGT_AW];
        end
    end

    // Out-of-range target indices never match any t, so they are simply ignored.
    always_comb begin
        logic [REQ_AW-1:0] cand;
        cand    = '0;
        win_vld = '0;
        for (int t = 0; t < TGT_NUM; t++) begin
            win[t] = '0;
            if (state_q[t] == S_LOCKED) begin
                if (REQ_ARB[owner_q[t]] && req_tgt[owner_q[t]] == TGT_AW'(t)) begin
                    win_vld[t] = 1'b1;
                    win[t]     = owner_q[t];
                end
            end else begin
                for (int k = 0; k < REQ_NUM; k++) begin
                    cand = rr_slot(ptr_q[t], k);
                    if (!win_vld[t] && REQ_ARB[cand] && req_tgt[cand] == TGT_AW'(t)) begin
                        win_vld[t] = 1'b1;
                        win[t]     = cand;
                    end
                end
            end
        end
    end

    always_comb begin
        GNT_ARB = '0;
        GNT_IDX = '0;
        for (int t = 0; t < TGT_NUM; t++) begin
            if (win_vld[t]) begin
                GNT_ARB[win[t]]              = 1'b1;
                GNT_IDX[t*REQ_AW +: REQ_AW] = win[t];
            end
        end
    end

    assign GNT_VLD = win_vld;

    always_comb begin
        logic xfer;
        logic last;
        xfer = 1'b0;
        last = 1'b0;
        for (int t = 0; t < TGT_NUM; t++) begin
            state_d[t] = state_q[t];
            ptr_d[t]   = ptr_q[t];
            owner_d[t] = owner_q[t];
            xfer       = win_vld[t] && TGT_RDY[t];
            last       = REQ_LAST[win[t]];
            if (xfer) begin
                if (state_q[t] == S_LOCKED) begin
                    if (last) begin
                        ptr_d[t]   = next_ptr(owner_q[t]);
                        state_d[t] = S_IDLE;
                    end
                end else if (last || !LOCK_EN) begin
                    ptr_d[t] = next_ptr(win[t]);
                end else begin
                    owner_d[t] = win[t];
                    state_d[t] = S_LOCKED;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < TGT_NUM; t++) begin
                state_q[t] <= S_IDLE;
                ptr_q[t]   <= '0;
                owner_q[t] <= '0;
            end
        end else begin
            for (int t = 0; t < TGT_NUM; t++) begin
                state_q[t] <= state_d[t];
                ptr_q[t]   <= ptr_d[t];
                owner_q[t] <= owner_d[t];
            end
        end
    end

    always_comb begin
        for (int t = 0; t < TGT_NUM; t++) begin
            LOCK[t] = (state_q[t] == S_LOCKED);
        end
    end

endmodule

// File: tb/tb_cpm_arb_mi_rr.sv
// tb/tb_cpm_arb_mi_rr.sv - table vectors, hand sequences and randomized model check for cpm_arb_mi_rr
// Instance 0 is 4x4, instance 1 is 3 requesters x 3 targets (index 3 is out of range).
module tb_cpm_arb_mi_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    always #5 clk = ~clk;

    logic [3:0] arb4, last4, rdy4, garb4, gvld4, lock4;
    logic [7:0] idx4, gidx4;
    logic [2:0] arb3, last3, rdy3, garb3, gvld3, lock3;
    logic [5:0] idx3, gidx3;

    cpm_arb_mi_rr #(.REQ_NUM(4), .TGT_NUM(4), .LOCK_EN(1'b1)) u4 (
        .clk(clk), .rst_n(rst_n), .REQ_ARB(arb4), .REQ_IDX(idx4), .REQ_LAST(last4),
        .TGT_RDY(rdy4), .GNT_ARB(garb4), .GNT_VLD(gvld4), .GNT_IDX(gidx4), .LOCK(lock4));

    cpm_arb_mi_rr #(.REQ_NUM(3), .TGT_NUM(3), .LOCK_EN(1'b1)) u3 (
        .clk(clk), .rst_n(rst_n), .REQ_ARB(arb3), .REQ_IDX(idx3), .REQ_LAST(last3),
        .TGT_RDY(rdy3), .GNT_ARB(garb3), .GNT_VLD(gvld3), .GNT_IDX(gidx3), .LOCK(lock3));

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: per instance, per target pointer / lock flag / owner.
    int         nreq [2] = '{4, 3};
    int         ntgt [2] = '{4, 3};
    int         m_ptr [2][4];
    bit         m_lock[2][4];
    int         m_own [2][4];
    bit         a_arb [2][4];
    logic [1:0] a_tgt [2][4];
    bit         a_last[2][4];
    bit         a_rdy [2][4];
    bit         keep  [2][4];

    typedef struct {
        logic [3:0] arb;
        logic [7:0] idx;
        logic [3:0] last;
        logic [3:0] rdy;
        logic [3:0] e_arb;
        logic [3:0] e_vld;
        logic [7:0] e_gidx;
        logic [3:0] e_lock;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int mgrant(int i, int t);
        int r;
        if (m_lock[i][t]) begin
            r = m_own[i][t];
            return (a_arb[i][r] && int'(a_tgt[i][r]) == t) ? r : -1;
        end
        for (int k = 0; k < nreq[i]; k++) begin
            r = (m_ptr[i][t] + k) % nreq[i];
            if (a_arb[i][r] && int'(a_tgt[i][r]) == t) return r;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++)
            for (int t = 0; t < 4; t++) begin
                m_ptr[i][t] = 0; m_lock[i][t] = 0; m_own[i][t] = 0;
            end
    endtask

    task automatic model_step();
        int g;
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 4; r++) keep[i][r] = 0;
            for (int t = 0; t < ntgt[i]; t++) begin
                g = mgrant(i, t);
                if (g >= 0 && !a_rdy[i][t]) keep[i][g] = 1;
                if (g >= 0 && a_rdy[i][t]) begin
                    if (a_last[i][g]) begin
                        m_ptr[i][t]  = (g + 1) % nreq[i];
                        m_lock[i][t] = 0;
                    end else begin
                        m_lock[i][t] = 1;
                        m_own[i][t]  = g;
                    end
                end
            end
        end
    endtask

    task automatic drive();
        for (int r = 0; r < 4; r++) begin
            arb4[r] = a_arb[0][r]; last4[r] = a_last[0][r]; rdy4[r] = a_rdy[0][r];
            idx4[r*2 +: 2] = a_tgt[0][r];
        end
        for (int r = 0; r < 3; r++) begin
            arb3[r] = a_arb[1][r]; last3[r] = a_last[1][r]; rdy3[r] = a_rdy[1][r];
            idx3[r*2 +: 2] = a_tgt[1][r];
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 4; r++) begin
                a_arb[i][r] = 0; a_tgt[i][r] = 0; a_last[i][r] = 1; a_rdy[i][r] = 1;
            end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] e_arb, e_vld, e_lock;
        logic [7:0] e_idx;
        int g;
        for (int i = 0; i < 2; i++) begin
            e_arb = '0; e_vld = '0; e_lock = '0; e_idx = '0;
            for (int t = 0; t < ntgt[i]; t++) begin
                g = mgrant(i, t);
                e_lock[t] = m_lock[i][t];
                if (g >= 0) begin
                    e_arb[g] = 1'b1;
                    e_vld[t] = 1'b1;
                    e_idx[t*2 +: 2] = 2'(g);
                end
            end
            if (i == 0) begin
                chk({tag, "_u4_arb"}, 32'(garb4), 32'(e_arb));
                chk({tag, "_u4_vld"}, 32'(gvld4), 32'(e_vld));
                chk({tag, "_u4_idx"}, 32'(gidx4), 32'(e_idx));
                chk({tag, "_u4_lock"}, 32'(lock4), 32'(e_lock));
            end else begin
                chk({tag, "_u3_arb"}, 32'(garb3), 32'(e_arb[2:0]));
                chk({tag, "_u3_vld"}, 32'(gvld3), 32'(e_vld[2:0]));
                chk({tag, "_u3_idx"}, 32'(gidx3), 32'(e_idx[5:0]));
                chk({tag, "_u3_lock"}, 32'(lock3), 32'(e_lock[2:0]));
            end
        end
    endtask

    initial begin
        // round-robin on t0, one-per-target, burst lock by r1, stalled r2 then r3
        tbl[0]  = '{4'hF, 8'h00, 4'hF, 4'hF, 4'h1, 4'h1, 8'h00, 4'h0};
        tbl[1]  = '{4'hF, 8'h00, 4'hF, 4'hF, 4'h2, 4'h1, 8'h01, 4'h0};
        tbl[2]  = '{4'hF, 8'h00, 4'hF, 4'hF, 4'h4, 4'h1, 8'h02, 4'h0};
        tbl[3]  = '{4'hF, 8'h00, 4'hF, 4'hF, 4'h8, 4'h1, 8'h03, 4'h0};
        tbl[4]  = '{4'hF, 8'hE4, 4'hF, 4'hF, 4'hF, 4'hF, 8'hE4, 4'h0};
        tbl[5]  = '{4'hF, 8'hE4, 4'hF, 4'hF, 4'hF, 4'hF, 8'hE4, 4'h0};
        tbl[6]  = '{4'h7, 8'h00, 4'h5, 4'hF, 4'h2, 4'h1, 8'h01, 4'h0};
        tbl[7]  = '{4'h7, 8'h00, 4'h5, 4'hF, 4'h2, 4'h1, 8'h01, 4'h1};
        tbl[8]  = '{4'h7, 8'h00, 4'h7, 4'hF, 4'h2, 4'h1, 8'h01, 4'h1};
        tbl[9]  = '{4'h7, 8'h00, 4'h7, 4'hF, 4'h4, 4'h1, 8'h02, 4'h0};
        for (int k = 10; k < 15; k++)
            tbl[k] = '{4'h4, 8'h00, 4'hF, 4'hE, 4'h4, 4'h1, 8'h02, 4'h0};
        tbl[15] = '{4'h4, 8'h00, 4'hF, 4'hF, 4'h4, 4'h1, 8'h02, 4'h0};
        tbl[16] = '{4'hF, 8'h00, 4'hF, 4'hF, 4'h8, 4'h1, 8'h03, 4'h0};

        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_u4_lock", 32'(lock4), 32'h0);
        chk("reset_u4_gnt", 32'(garb4), 32'h0);
        chk("reset_u4_vld", 32'(gvld4), 32'h0);
        chk("reset_u3_lock", 32'(lock3), 32'h0);
        rst_n = 1'b1;

        for (int k = 0; k < 17; k++) begin
            for (int r = 0; r < 4; r++) begin
                a_arb[0][r]  = tbl[k].arb[r];
                a_tgt[0][r]  = tbl[k].idx[r*2 +: 2];
                a_last[0][r] = tbl[k].last[r];
                a_rdy[0][r]  = tbl[k].rdy[r];
            end
            drive();
            @(negedge clk);
            chk($sformatf("vec%0d_arb", k), 32'(garb4), 32'(tbl[k].e_arb));
            chk($sformatf("vec%0d_vld", k), 32'(gvld4), 32'(tbl[k].e_vld));
            chk($sformatf("vec%0d_idx", k), 32'(gidx4), 32'(tbl[k].e_gidx));
            chk($sformatf("vec%0d_lock", k), 32'(lock4), 32'(tbl[k].e_lock));
            @(posedge clk);
            model_step();
            #1;
        end

        // REQ_NUM=3: pointer wraps 2 -> 0; target index 3 is never granted
        clear_inputs();
        a_arb[1][2] = 1; a_tgt[1][2] = 2'd1;
        drive();
        @(negedge clk);
        chk("wrap_r2_arb", 32'(garb3), 32'h4);
        chk("wrap_r2_idx", 32'(gidx3), 32'h08);
        @(posedge clk); model_step(); #1;
        a_arb[1][0] = 1; a_tgt[1][0] = 2'd1;
        drive();
        @(negedge clk);
        chk("wrap_r0_arb", 32'(garb3), 32'h1);
        chk("wrap_r0_vld", 32'(gvld3), 32'h2);
        @(posedge clk); model_step(); #1;
        clear_inputs();
        a_arb[1][1] = 1; a_tgt[1][1] = 2'd3;
        drive();
        @(negedge clk);
        chk("oor_arb", 32'(garb3), 32'h0);
        chk("oor_vld", 32'(gvld3), 32'h0);
        @(posedge clk); model_step(); #1;

        // lock t1 with r3, then reset mid-burst
        clear_inputs();
        a_arb[0][3] = 1; a_tgt[0][3] = 2'd1; a_last[0][3] = 0;
        drive();
        @(negedge clk);
        chk("lk_arb", 32'(garb4), 32'h8);
        chk("lk_idx", 32'(gidx4), 32'h0C);
        @(posedge clk); model_step(); #1;
        chk("lk_lock", 32'(lock4), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_lock", 32'(lock4), 32'h0);
        model_reset();
        clear_inputs();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin a_arb[0][r] = 1; a_tgt[0][r] = 2'd1; end
        drive();
        @(negedge clk);
        chk("post_rst_arb", 32'(garb4), 32'h1);
        chk("post_rst_vld", 32'(gvld4), 32'h2);
        chk("post_rst_idx", 32'(gidx4), 32'h00);
        @(posedge clk); model_step(); #1;

        // randomized traffic; stalled grantees keep their request stable
        for (int r = 0; r < 4; r++) begin keep[0][r] = 0; keep[1][r] = 0; end
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < 2; i++) begin
                for (int r = 0; r < nreq[i]; r++) begin
                    if (!keep[i][r]) begin
                        a_arb[i][r]  = ($urandom_range(0, 3) != 0);
                        a_tgt[i][r]  = 2'($urandom_range(0, 3));
                        a_last[i][r] = ($urandom_range(0, 2) != 0);
                    end
                end
                for (int t = 0; t < ntgt[i]; t++) a_rdy[i][t] = ($urandom_range(0, 3) != 0);
            end
            drive();
            @(negedge clk);
            check_model($sformatf("rnd%0d", c));
            @(posedge clk);
            model_step();
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
